// File: rtl/bcd_counter_4dig.sv
// Four-digit BCD event counter fed by an asynchronous, debounced event line.
// Optional up/down counting with a dir port is enabled by defining BCD_UPDOWN_EN.
module bcd_counter_4dig #(
  parameter int SYNC_STAGES = 2,
  parameter bit WRAP        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_in,
  input  logic        en,
  input  logic        clr,
`ifdef BCD_UPDOWN_EN
  input  logic        dir,
`endif
  output logic [15:0] bcd,
  output logic        tick,
  output logic        carry,
  output logic        ovf
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   inc;
  logic                   down;

  logic [15:0] bcd_q, bcd_d;
  logic        tick_q, tick_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;

  logic [15:0] step_val;
  logic        step_out;
  logic        ripple;
  logic [3:0]  digit;

`ifdef BCD_UPDOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // Stages and history reset high so a line already high at reset release is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cnt_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign inc = sync_q[SYNC_STAGES-1] & ~hist_q;

  // One-step ripple; step_out flags that the top digit carried/borrowed out.
  always_comb begin
    step_val = '0;
    ripple   = 1'b1;
    digit    = '0;
    for (int i = 0; i < 4; i++) begin
      digit = bcd_q[4*i +: 4];
      if (!ripple) begin
        step_val[4*i +: 4] = digit;
      end else if (down) begin
        if (digit == 4'd0) begin
          step_val[4*i +: 4] = 4'd9;
          ripple             = 1'b1;
        end else if (digit > 4'd9) begin
          step_val[4*i +: 4] = 4'd8;
          ripple             = 1'b0;
        end else begin
          step_val[4*i +: 4] = digit - 4'd1;
          ripple             = 1'b0;
        end
      end else begin
        if (digit >= 4'd9) begin
          step_val[4*i +: 4] = 4'd0;
          ripple             = 1'b1;
        end else begin
          step_val[4*i +: 4] = digit + 4'd1;
          ripple             = 1'b0;
        end
      end
    end
    step_out = ripple;
  end

  always_comb begin
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    ovf_d   = ovf_q;
    tick_d  = inc;
    if (clr) begin
      bcd_d = '0;
      ovf_d = 1'b0;
    end else if (en && inc) begin
      if (!step_out) begin
        bcd_d = step_val;
      end else if (WRAP) begin
        bcd_d   = step_val;
        carry_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd   = bcd_q;
  assign tick  = tick_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_counter_4dig.sv
// Bench for bcd_counter_4dig: a wrapping and a saturating instance share stimulus,
// checked every cycle against an integer event-count model plus literal pins.
module tb_bcd_counter_4dig;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic cnt_in;
  logic en;
  logic clr;
`ifdef BCD_UPDOWN_EN
  logic dir;
`endif

  logic [15:0] bcd_w, bcd_s;
  logic        tick_w, tick_s, carry_w, carry_s, ovf_w, ovf_s;

  int checks = 0;
  int failures = 0;
  int tick_total = 0;
  int carry_total_w = 0;
  int carry_total_s = 0;
  int snap;

  always #5 clk = ~clk;

  bcd_counter_4dig #(.SYNC_STAGES(SS), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .en(en), .clr(clr),
`ifdef BCD_UPDOWN_EN
    .dir(dir),
`endif
    .bcd(bcd_w), .tick(tick_w), .carry(carry_w), .ovf(ovf_w)
  );

  bcd_counter_4dig #(.SYNC_STAGES(SS), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .en(en), .clr(clr),
`ifdef BCD_UPDOWN_EN
    .dir(dir),
`endif
    .bcd(bcd_s), .tick(tick_s), .carry(carry_s), .ovf(ovf_s)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic int next_cnt(input int c, input bit wrap, input bit dn);
    if (dn) return (c == 0) ? (wrap ? 9999 : 0) : c - 1;
    return (c == 9999) ? (wrap ? 0 : 9999) : c + 1;
  endfunction

  function automatic bit at_limit(input int c, input bit dn);
    return dn ? (c == 0) : (c == 9999);
  endfunction

  // Model: m_c[k] is cnt_in as sampled k+1 edges ago; an event is a 0->1 step
  // in that sampled history, seen SS edges after it was first sampled.
  logic [SS:0] m_c;
  int          m_cnt_w, m_cnt_s;
  logic        m_tick, m_carry_w, m_carry_s, m_ovf_w, m_ovf_s;
  logic        m_ev;
  logic        m_dn;

  assign m_ev = m_c[SS-1] & ~m_c[SS];
`ifdef BCD_UPDOWN_EN
  assign m_dn = dir;
`else
  assign m_dn = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_c       <= '1;
      m_cnt_w   <= 0;
      m_cnt_s   <= 0;
      m_tick    <= 1'b0;
      m_carry_w <= 1'b0;
      m_carry_s <= 1'b0;
      m_ovf_w   <= 1'b0;
      m_ovf_s   <= 1'b0;
    end else begin
      m_c    <= {m_c[SS-1:0], cnt_in};
      m_tick <= m_ev;
      if (clr) begin
        m_cnt_w   <= 0;
        m_cnt_s   <= 0;
        m_carry_w <= 1'b0;
        m_carry_s <= 1'b0;
        m_ovf_w   <= 1'b0;
        m_ovf_s   <= 1'b0;
      end else if (en && m_ev) begin
        m_cnt_w   <= next_cnt(m_cnt_w, 1'b1, m_dn);
        m_carry_w <= at_limit(m_cnt_w, m_dn);
        m_cnt_s   <= next_cnt(m_cnt_s, 1'b0, m_dn);
        m_carry_s <= 1'b0;
        if (at_limit(m_cnt_s, m_dn)) m_ovf_s <= 1'b1;
      end else begin
        m_carry_w <= 1'b0;
        m_carry_s <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("bcd_w", bcd_w, to_bcd(m_cnt_w));
      chk("bcd_s", bcd_s, to_bcd(m_cnt_s));
      chk("tick_w", {15'd0, tick_w}, {15'd0, m_tick});
      chk("tick_s", {15'd0, tick_s}, {15'd0, m_tick});
      chk("carry_w", {15'd0, carry_w}, {15'd0, m_carry_w});
      chk("carry_s", {15'd0, carry_s}, {15'd0, m_carry_s});
      chk("ovf_w", {15'd0, ovf_w}, {15'd0, m_ovf_w});
      chk("ovf_s", {15'd0, ovf_s}, {15'd0, m_ovf_s});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tick_w)  tick_total    <= tick_total + 1;
      if (carry_w) carry_total_w <= carry_total_w + 1;
      if (carry_s) carry_total_s <= carry_total_s + 1;
    end
  end

  task automatic pulse(input int hi, input int lo);
    cnt_in = 1'b1;
    repeat (hi) @(negedge clk);
    cnt_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic clear_once();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    cnt_in = 1'b1;
    en     = 1'b1;
    clr    = 1'b0;
`ifdef BCD_UPDOWN_EN
    dir    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_bcd_w", bcd_w, 16'h0000);
    chk("reset_ovf_s", {15'd0, ovf_s}, 16'h0000);
    rst_n = 1'b1;

    // Input held high through reset release must not count.
    repeat (10) @(negedge clk);
    chk("hold_high_bcd", bcd_w, 16'h0000);
    chk("hold_high_ticks", 16'(tick_total), 16'd0);
    cnt_in = 1'b0;
    repeat (5) @(negedge clk);

    // First pulse: update lands on the third rising edge after the rise is sampled.
    cnt_in = 1'b1;
    @(posedge clk); #1 chk("lat_edge1", bcd_w, 16'h0000);
    @(posedge clk); #1 chk("lat_edge2", bcd_w, 16'h0000);
    @(posedge clk); #1 chk("lat_edge3", bcd_w, 16'h0001);
    repeat (2) @(negedge clk);
    cnt_in = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 11; i++) pulse(5, 5);
    chk("twelve_w", bcd_w, 16'h0012);
    chk("twelve_s", bcd_s, 16'h0012);

    // Events with en=0 are dropped; raising en while high does not count.
    clear_once();
    snap = tick_total;
    en = 1'b0;
    pulse(5, 5);
    pulse(5, 5);
    cnt_in = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    cnt_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("en_off_bcd", bcd_w, 16'h0000);
    chk("en_off_ticks", 16'(tick_total - snap), 16'd3);

    // clr coincident with an increment wins.
    for (int i = 0; i < 42; i++) pulse(3, 3);
    chk("pre_clr_42", bcd_w, 16'h0042);
    cnt_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_vs_inc", bcd_w, 16'h0000);
    repeat (3) @(negedge clk);
    cnt_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("clr_vs_inc_after", bcd_s, 16'h0000);

    // Preload to 9999, then one more event.
    for (int i = 0; i < 9999; i++) pulse(3, 3);
    chk("preload_w", bcd_w, 16'h9999);
    chk("preload_s", bcd_s, 16'h9999);
    chk("preload_ovf_s", {15'd0, ovf_s}, 16'h0000);
    snap = carry_total_w;
    pulse(3, 5);
    chk("wrap_bcd", bcd_w, 16'h0000);
    chk("wrap_carry_cycles", 16'(carry_total_w - snap), 16'd1);
    chk("sat_bcd", bcd_s, 16'h9999);
    chk("sat_ovf", {15'd0, ovf_s}, 16'h0001);
    chk("sat_carry_cycles", 16'(carry_total_s), 16'd0);
    pulse(3, 5);
    chk("sat_ovf_sticky", {15'd0, ovf_s}, 16'h0001);
    clear_once();
    chk("sat_clr_bcd", bcd_s, 16'h0000);
    chk("sat_clr_ovf", {15'd0, ovf_s}, 16'h0000);

`ifdef BCD_UPDOWN_EN
    dir = 1'b1;
    snap = carry_total_w;
    pulse(3, 5);
    chk("down_wrap_bcd", bcd_w, 16'h9999);
    chk("down_wrap_carry", 16'(carry_total_w - snap), 16'd1);
    chk("down_sat_bcd", bcd_s, 16'h0000);
    chk("down_sat_ovf", {15'd0, ovf_s}, 16'h0001);
    clear_once();
    dir = 1'b0;
    for (int i = 0; i < 100; i++) pulse(3, 3);
    chk("up_to_100", bcd_w, 16'h0100);
    dir = 1'b1;
    pulse(3, 5);
    chk("down_100_w", bcd_w, 16'h0099);
    chk("down_100_s", bcd_s, 16'h0099);
    dir = 1'b0;
`endif

    // Mid-operation reset clears everything at once.
    pulse(3, 5);
    rst_n = 1'b0;
    #1;
    chk("async_reset_bcd", bcd_s, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
